// File: rtl/decode_execute_pipe_stage_pkg.sv
// rtl/decode_execute_pipe_stage_pkg.sv - shared widths, stage state and payload types for the decode->execute boundary
package decode_execute_pipe_stage_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_OP_W    = 4;
  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_RD_W    = 4;
  localparam int DEF_SKID    = 1;

  // EMPTY: nothing held, BUSY: main register valid, FULL: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Payload at the default widths; the stage rebuilds it from its own parameters
  typedef struct packed {
    logic [DEF_OP_W-1:0]                alu_op;
    logic [DEF_NUM_SRC*DEF_DATA_W-1:0]  src;
    logic [DEF_RD_W-1:0]                rd;
    logic                               wr_en;
  } de_payload_t;

  // Number of instructions held in a given state
  function automatic logic [1:0] occupancy_of(stage_state_e s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_execute_pipe_stage_if.sv
// rtl/decode_execute_pipe_stage_if.sv - instruction handshake bus between pipeline stages
interface decode_execute_pipe_stage_if #(
  parameter int DATA_W  = decode_execute_pipe_stage_pkg::DEF_DATA_W,
  parameter int OP_W    = decode_execute_pipe_stage_pkg::DEF_OP_W,
  parameter int NUM_SRC = decode_execute_pipe_stage_pkg::DEF_NUM_SRC,
  parameter int RD_W    = decode_execute_pipe_stage_pkg::DEF_RD_W
) ();

  logic                      valid;
  logic                      ready;
  logic [OP_W-1:0]           alu_op;
  logic [NUM_SRC*DATA_W-1:0] src;
  logic [RD_W-1:0]           rd;
  logic                      wr_en;

  modport master (output valid, alu_op, src, rd, wr_en, input ready);
  modport slave  (input valid, alu_op, src, rd, wr_en, output ready);

endinterface

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry skid buffer with registered in_ready and flush-to-bubble
module pipe_skid_buffer
  import decode_execute_pipe_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  stage_state_e     state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Main register feeds the ALU; the skid register absorbs the one beat
  // accepted while the ALU stalls, which lets in_ready come straight from a flop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush_i) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q      <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data_i;
          end else if (in_fire) begin
            skid_q     <= in_data_i;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= BUSY;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Held low while reset is asserted so decode never sees a phantom accept
  assign in_ready_o  = in_ready_q & rst_ni;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign occupancy_o = occupancy_of(state_q);

endmodule

// File: rtl/decode_execute_pipe_stage.sv
// rtl/decode_execute_pipe_stage.sv - decode->execute pipeline register with handshake, stall and flush
module decode_execute_pipe_stage
  import decode_execute_pipe_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int RD_W    = DEF_RD_W,
  parameter int SKID    = DEF_SKID
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        flush_i,
  decode_execute_pipe_stage_if.slave  in_if,
  decode_execute_pipe_stage_if.master out_if,
  output logic [1:0]                  occupancy_o
);

  typedef struct packed {
    logic [OP_W-1:0]           alu_op;
    logic [NUM_SRC*DATA_W-1:0] src;
    logic [RD_W-1:0]           rd;
    logic                      wr_en;
  } payload_t;

  localparam int PL_W = $bits(payload_t);

  payload_t in_pl;
  payload_t out_pl;
  logic     out_valid;

  assign in_pl.alu_op = in_if.alu_op;
  assign in_pl.src    = in_if.src;
  assign in_pl.rd     = in_if.rd;
  assign in_pl.wr_en  = in_if.wr_en;

  if (SKID != 0) begin : g_skid
    logic [PL_W-1:0] out_data;

    pipe_skid_buffer #(
      .WIDTH(PL_W)
    ) u_skid (
      .clk_i       (clk_i),
      .rst_ni      (rst_n_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_if.valid),
      .in_ready_o  (in_if.ready),
      .in_data_i   (in_pl),
      .out_valid_o (out_valid),
      .out_ready_i (out_if.ready),
      .out_data_o  (out_data),
      .occupancy_o (occupancy_o)
    );

    assign out_pl = payload_t'(out_data);
  end else begin : g_single
    payload_t data_q;
    payload_t data_d;
    logic     valid_q;
    logic     valid_d;
    logic     in_ready;
    logic     in_fire;
    logic     out_fire;

    // Accept whenever the register is empty or being drained this cycle
    assign in_ready = rst_n_i & (~valid_q | out_if.ready);
    assign in_fire  = in_if.valid & in_ready;
    assign out_fire = valid_q & out_if.ready;

    // Next contents: a new instruction replaces the old one even if it leaves this cycle
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_fire) begin
        valid_d = 1'b1;
        data_d  = in_pl;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

    // Single holding register; flush only drops valid, payload may go stale
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign in_if.ready = in_ready;
    assign out_valid   = valid_q;
    assign out_pl      = data_q;
    assign occupancy_o = {1'b0, valid_q};
  end

  assign out_if.valid  = out_valid;
  assign out_if.alu_op = out_pl.alu_op;
  assign out_if.src    = out_pl.src;
  assign out_if.rd     = out_pl.rd;
  // A bubble must never request a register write
  assign out_if.wr_en  = out_pl.wr_en & out_valid;

endmodule

// File: tb/tb_decode_execute_pipe_stage.sv
// tb/tb_decode_execute_pipe_stage.sv - scoreboard bench for both skid and single-register variants
module tb_decode_execute_pipe_stage;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // ---------------- instance A: SKID=1, default widths ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] src;
    logic [3:0]  rd;
    logic        wr;
  } pa_t;

  logic       a_rst_n = 1'b0;
  logic       a_flush = 1'b0;
  logic [1:0] occ_a;

  decode_execute_pipe_stage_if #(.DATA_W(16), .OP_W(4), .NUM_SRC(2), .RD_W(4)) ai ();
  decode_execute_pipe_stage_if #(.DATA_W(16), .OP_W(4), .NUM_SRC(2), .RD_W(4)) ao ();

  decode_execute_pipe_stage #(
    .DATA_W(16), .OP_W(4), .NUM_SRC(2), .RD_W(4), .SKID(1)
  ) dut_a (
    .clk_i       (clk),
    .rst_n_i     (a_rst_n),
    .flush_i     (a_flush),
    .in_if       (ai),
    .out_if      (ao),
    .occupancy_o (occ_a)
  );

  pa_t qa[$];
  bit  started_a = 1'b0;
  bit  pa_rst    = 1'b0;
  bit  pa_fl     = 1'b0;
  bit  pa_fire   = 1'b0;
  pa_t pa_pl;

  task automatic cyc_a(input bit rst, input bit fl, input bit v, input logic [3:0] op,
                       input logic [31:0] s, input logic [3:0] rd, input bit wr, input bit ordy);
    bit       exp_rdy;
    int       exp_occ;
    bit       zero_chk;
    @(posedge clk);
    #1;
    if (!pa_rst || pa_fl) qa.delete();
    else if (pa_fire) qa.push_back(pa_pl);
    started_a = 1'b1;
    zero_chk  = !pa_rst;
    a_rst_n   = rst;
    a_flush   = fl;
    ai.valid  = v;
    ai.alu_op = op;
    ai.src    = s;
    ai.rd     = rd;
    ai.wr_en  = wr;
    ao.ready  = ordy;
    exp_rdy   = rst && (qa.size() < 2);
    exp_occ   = qa.size();
    pa_rst    = rst;
    pa_fl     = fl;
    pa_fire   = v && exp_rdy;
    pa_pl     = '{op: op, src: s, rd: rd, wr: wr};
    @(negedge clk);
    chk("a_in_ready", 128'(ai.ready), 128'(exp_rdy));
    chk("a_occupancy", 128'(occ_a), 128'(exp_occ));
    if (zero_chk)
      chk("a_reset_payload", 128'({ao.alu_op, ao.src, ao.rd, ao.wr_en}), 128'(0));
  endtask

  // Monitor A: whatever the stage presents must be the oldest accepted instruction
  always @(negedge clk) begin
    if (started_a) begin
      chk("a_out_valid", 128'(ao.valid), 128'(qa.size() != 0));
      if (ao.valid && qa.size() != 0) begin
        chk("a_alu_op", 128'(ao.alu_op), 128'(qa[0].op));
        chk("a_src", 128'(ao.src), 128'(qa[0].src));
        chk("a_rd", 128'(ao.rd), 128'(qa[0].rd));
        chk("a_wr_en", 128'(ao.wr_en), 128'(qa[0].wr));
      end
      if (!ao.valid) chk("a_bubble_wr_en", 128'(ao.wr_en), 128'(0));
      if (ao.valid && ao.ready && a_rst_n && !a_flush && qa.size() != 0) void'(qa.pop_front());
    end
  end

  // ---------------- instance B: SKID=0, NUM_SRC=3, DATA_W=32 ----------------
  typedef struct {
    logic [3:0]  op;
    logic [95:0] src;
    logic [3:0]  rd;
    logic        wr;
  } pb_t;

  logic       b_rst_n = 1'b0;
  logic       b_flush = 1'b0;
  logic [1:0] occ_b;

  decode_execute_pipe_stage_if #(.DATA_W(32), .OP_W(4), .NUM_SRC(3), .RD_W(4)) bi ();
  decode_execute_pipe_stage_if #(.DATA_W(32), .OP_W(4), .NUM_SRC(3), .RD_W(4)) bo ();

  decode_execute_pipe_stage #(
    .DATA_W(32), .OP_W(4), .NUM_SRC(3), .RD_W(4), .SKID(0)
  ) dut_b (
    .clk_i       (clk),
    .rst_n_i     (b_rst_n),
    .flush_i     (b_flush),
    .in_if       (bi),
    .out_if      (bo),
    .occupancy_o (occ_b)
  );

  pb_t qb[$];
  bit  started_b = 1'b0;
  bit  pb_rst    = 1'b0;
  bit  pb_fl     = 1'b0;
  bit  pb_fire   = 1'b0;
  pb_t pb_pl;

  task automatic cyc_b(input bit rst, input bit fl, input bit v, input logic [3:0] op,
                       input logic [95:0] s, input logic [3:0] rd, input bit wr, input bit ordy);
    bit exp_rdy;
    int exp_occ;
    @(posedge clk);
    #1;
    if (!pb_rst || pb_fl) qb.delete();
    else if (pb_fire) qb.push_back(pb_pl);
    started_b = 1'b1;
    b_rst_n   = rst;
    b_flush   = fl;
    bi.valid  = v;
    bi.alu_op = op;
    bi.src    = s;
    bi.rd     = rd;
    bi.wr_en  = wr;
    bo.ready  = ordy;
    exp_rdy   = rst && (qb.size() == 0 || ordy);
    exp_occ   = qb.size();
    pb_rst    = rst;
    pb_fl     = fl;
    pb_fire   = v && exp_rdy;
    pb_pl     = '{op: op, src: s, rd: rd, wr: wr};
    @(negedge clk);
    chk("b_in_ready", 128'(bi.ready), 128'(exp_rdy));
    chk("b_occupancy", 128'(occ_b), 128'(exp_occ));
  endtask

  // Monitor B: same ordering rule with a single-entry store
  always @(negedge clk) begin
    if (started_b) begin
      chk("b_out_valid", 128'(bo.valid), 128'(qb.size() != 0));
      if (bo.valid && qb.size() != 0) begin
        chk("b_alu_op", 128'(bo.alu_op), 128'(qb[0].op));
        chk("b_src", 128'(bo.src), 128'(qb[0].src));
        chk("b_rd", 128'(bo.rd), 128'(qb[0].rd));
        chk("b_wr_en", 128'(bo.wr_en), 128'(qb[0].wr));
      end
      if (!bo.valid) chk("b_bubble_wr_en", 128'(bo.wr_en), 128'(0));
      if (bo.valid && bo.ready && b_rst_n && !b_flush && qb.size() != 0) void'(qb.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ai.valid = 1'b0; ai.alu_op = '0; ai.src = '0; ai.rd = '0; ai.wr_en = 1'b0; ao.ready = 1'b0;
    bi.valid = 1'b0; bi.alu_op = '0; bi.src = '0; bi.rd = '0; bi.wr_en = 1'b0; bo.ready = 1'b0;

    // reset held two cycles with decode presenting an instruction
    cyc_a(0, 0, 1, 4'h9, 32'hdead_beef, 4'h7, 1, 1);
    cyc_a(0, 0, 1, 4'h9, 32'hdead_beef, 4'h7, 1, 1);

    // back-to-back streaming
    cyc_a(1, 0, 1, 4'h3, {16'h0001, 16'h0002}, 4'h1, 1, 1);
    cyc_a(1, 0, 1, 4'h5, {16'h0003, 16'h0004}, 4'h2, 1, 1);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);

    // stall for three cycles with input pending, then release
    cyc_a(1, 0, 1, 4'ha, 32'h1111_2222, 4'h3, 1, 0);
    cyc_a(1, 0, 1, 4'hb, 32'h3333_4444, 4'h4, 0, 0);
    cyc_a(1, 0, 1, 4'hc, 32'h5555_6666, 4'h5, 1, 0);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);

    // flush while FULL with an instruction on the input
    cyc_a(1, 0, 1, 4'h1, 32'haaaa_0001, 4'h6, 1, 0);
    cyc_a(1, 0, 1, 4'h2, 32'haaaa_0002, 4'h7, 1, 0);
    cyc_a(1, 1, 1, 4'h3, 32'haaaa_0003, 4'h8, 1, 0);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);

    // flush and reset together: reset clears the payload
    cyc_a(1, 0, 1, 4'hf, 32'hffff_ffff, 4'hf, 1, 0);
    cyc_a(0, 1, 1, 4'he, 32'heeee_eeee, 4'he, 1, 1);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);

    // flush while the ALU is ready: held entry is discarded, not consumed
    cyc_a(1, 0, 1, 4'h7, 32'h7777_0000, 4'h9, 1, 0);
    cyc_a(1, 1, 1, 4'h8, 32'h8888_0000, 4'ha, 1, 1);
    cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      cyc_a($urandom_range(0, 99) != 0, $urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)),
            4'($urandom), $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) cyc_a(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 1);

    // single-register variant: reset then random handshake toggling
    cyc_b(0, 0, 1, 4'h1, 96'h1, 4'h1, 1, 1);
    cyc_b(0, 0, 1, 4'h1, 96'h1, 4'h1, 1, 1);
    for (int i = 0; i < 400; i++) begin
      cyc_b($urandom_range(0, 149) != 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
            4'($urandom), {$urandom, $urandom, $urandom}, 4'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) cyc_b(1, 0, 0, 4'h0, 96'h0, 4'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
